// File: rtl/switch_controller_if.sv
// Gate-drive bundle between the break-before-make controller and its environment.
// The master side is the controller; the slave side is the switch stage plus comparators.
interface switch_controller_if;
  logic uv;
  logic oc;
  logic zc;
  logic gp_ack;
  logic gn_ack;
  logic fault_clr;
  logic gp;
  logic gn;
  logic busy;
  logic fault;

  modport master (
    input  uv, oc, zc, gp_ack, gn_ack, fault_clr,
    output gp, gn, busy, fault
  );

  modport slave (
    output uv, oc, zc, gp_ack, gn_ack, fault_clr,
    input  gp, gn, busy, fault
  );
endinterface

// File: rtl/switch_controller.sv
// Break-before-make gate sequencer for a buck converter's PMOS/NMOS switches.
// Optional acknowledge-timeout fault handling is enabled with SWCTRL_ACK_TIMEOUT_EN.
module switch_controller #(
  parameter int unsigned DEAD_CYCLES   = 4,
  parameter int unsigned MIN_ON_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT   = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  switch_controller_if.master sw
);

  localparam int unsigned N_SYNC = 5;
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_ON_CYCLES);

  typedef enum logic [3:0] {
    IDLE,
    P_ON_REQ,
    P_ON,
    P_OFF_REQ,
    DEAD_PN,
    N_ON_REQ,
    N_ON,
    N_OFF_REQ,
    DEAD_NP
`ifdef SWCTRL_ACK_TIMEOUT_EN
    , FAULT
`endif
  } state_e;

  logic [N_SYNC-1:0] async_in;
  logic [N_SYNC-1:0] sync1_d, sync1_q;
  logic [N_SYNC-1:0] sync2_d, sync2_q;
  logic uv_s, oc_s, zc_s, gp_ack_s, gn_ack_s;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] cnt_on_inc_c;
  logic             gp_d, gp_q;
  logic             gn_d, gn_q;
  logic             busy_d, busy_q;
  logic             req_wait_c;

  assign async_in = {sw.uv, sw.oc, sw.zc, sw.gp_ack, sw.gn_ack};
  assign {uv_s, oc_s, zc_s, gp_ack_s, gn_ack_s} = sync2_q;

  // Two-flop synchronizers for every comparator and acknowledge input.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
  end

  assign cnt_inc_c    = cnt_q + CNT_W'(1);
  assign cnt_on_inc_c = (cnt_q >= MIN_C) ? cnt_q : cnt_inc_c;

  // Next-state logic; counter comparisons use the post-increment value so the
  // transition lands on the edge where the count is reached.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gp_d       = gp_q;
    gn_d       = gn_q;
    req_wait_c = 1'b0;

    case (state_q)
      IDLE: begin
        gp_d = 1'b0;
        gn_d = 1'b0;
        // NMOS must be seen off before a new charge phase, e.g. after a reset mid-cycle.
        if (uv_s && !oc_s && !gn_ack_s) begin
          gp_d    = 1'b1;
          state_d = P_ON_REQ;
          cnt_d   = '0;
        end
      end
      P_ON_REQ: begin
        if (gp_ack_s) begin
          state_d = P_ON;
          cnt_d   = '0;
        end else begin
          req_wait_c = 1'b1;
        end
      end
      P_ON: begin
        cnt_d = cnt_on_inc_c;
        if (oc_s && (cnt_on_inc_c >= MIN_C)) begin
          gp_d    = 1'b0;
          state_d = P_OFF_REQ;
          cnt_d   = '0;
        end
      end
      P_OFF_REQ: begin
        if (!gp_ack_s) begin
          state_d = DEAD_PN;
          cnt_d   = '0;
        end else begin
          req_wait_c = 1'b1;
        end
      end
      DEAD_PN: begin
        cnt_d = cnt_inc_c;
        if (cnt_inc_c >= DEAD_C) begin
          gn_d    = 1'b1;
          state_d = N_ON_REQ;
          cnt_d   = '0;
        end
      end
      N_ON_REQ: begin
        if (gn_ack_s) begin
          state_d = N_ON;
          cnt_d   = '0;
        end else begin
          req_wait_c = 1'b1;
        end
      end
      N_ON: begin
        if (zc_s || uv_s) begin
          gn_d    = 1'b0;
          state_d = N_OFF_REQ;
          cnt_d   = '0;
        end
      end
      N_OFF_REQ: begin
        if (!gn_ack_s) begin
          state_d = DEAD_NP;
          cnt_d   = '0;
        end else begin
          req_wait_c = 1'b1;
        end
      end
      DEAD_NP: begin
        cnt_d = cnt_inc_c;
        if (cnt_inc_c >= DEAD_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`ifdef SWCTRL_ACK_TIMEOUT_EN
      FAULT: begin
        gp_d = 1'b0;
        gn_d = 1'b0;
        if (sw.fault_clr && !gp_ack_s && !gn_ack_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gp_d    = 1'b0;
        gn_d    = 1'b0;
      end
    endcase

`ifdef SWCTRL_ACK_TIMEOUT_EN
    // Acknowledge watchdog shared by all request states.
    if (req_wait_c) begin
      if (cnt_q >= CNT_W'(ACK_TIMEOUT)) begin
        state_d = FAULT;
        gp_d    = 1'b0;
        gn_d    = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc_c;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      gp_q    <= 1'b0;
      gn_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gp_q    <= gp_d;
      gn_q    <= gn_d;
      busy_q  <= busy_d;
    end
  end

  assign sw.gp   = gp_q;
  assign sw.gn   = gn_q;
  assign sw.busy = busy_q;

`ifdef SWCTRL_ACK_TIMEOUT_EN
  logic fault_d, fault_q;

  always_comb begin
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign sw.fault = fault_q;
`else
  // Without the watchdog there is no fault path; the clear input and timeout are don't-cares.
  localparam int unsigned unused_ack_timeout = ACK_TIMEOUT;
  logic unused_fault_clr;
  logic unused_req_wait;
  assign unused_fault_clr = sw.fault_clr;
  assign unused_req_wait  = req_wait_c;
  assign sw.fault         = 1'b0;
`endif

endmodule

// File: tb/tb_switch_controller.sv
// Directed bench for switch_controller: timing of each handshake step, oc priority,
// minimum on-time, reset mid-cycle and (with SWCTRL_ACK_TIMEOUT_EN) the acknowledge watchdog.
module tb_switch_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  switch_controller_if sw_if ();

  switch_controller #(
    .DEAD_CYCLES  (4),
    .MIN_ON_CYCLES(8),
    .ACK_TIMEOUT  (64),
    .CNT_W        (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Both switches must never be commanded on together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ((sw_if.gp & sw_if.gn) !== 1'b1)
      else begin
        errors++;
        $error("FAIL overlap observed gp=%0b gn=%0b expected not both 1", sw_if.gp, sw_if.gn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    sw_if.uv = 1'b0;
    sw_if.oc = 1'b0;
    sw_if.zc = 1'b0;
    sw_if.gp_ack = 1'b0;
    sw_if.gn_ack = 1'b0;
    sw_if.fault_clr = 1'b0;
    tick(2);
    check("rst_gp", sw_if.gp, 1'b0);
    check("rst_gn", sw_if.gn, 1'b0);
    check("rst_busy", sw_if.busy, 1'b0);
    check("rst_fault", sw_if.fault, 1'b0);
    rst = 1'b0;
    tick(1);

    // Full cycle: uv pulse -> gp at 3rd edge
    sw_if.uv = 1'b1;
    tick(2);
    check("uv_lat_early", sw_if.gp, 1'b0);
    check("uv_busy_early", sw_if.busy, 1'b0);
    tick(1);
    check("uv_lat_gp", sw_if.gp, 1'b1);
    check("uv_lat_busy", sw_if.busy, 1'b1);
    sw_if.uv = 1'b0;
    tick(2);

    // gp_ack and oc together: P_ON at 3rd edge, gp held until counter reaches 8
    sw_if.gp_ack = 1'b1;
    sw_if.oc = 1'b1;
    tick(10);
    check("min_on_hold", sw_if.gp, 1'b1);
    tick(1);
    check("min_on_release", sw_if.gp, 1'b0);
    sw_if.oc = 1'b0;
    tick(2);

    // gn rises exactly 7 edges after gp_ack falls
    sw_if.gp_ack = 1'b0;
    tick(6);
    check("dead_pn_early", sw_if.gn, 1'b0);
    tick(1);
    check("dead_pn_gn", sw_if.gn, 1'b1);
    check("dead_pn_gp", sw_if.gp, 1'b0);
    tick(2);

    sw_if.gn_ack = 1'b1;
    tick(3);
    check("n_on_gn", sw_if.gn, 1'b1);
    sw_if.zc = 1'b1;
    tick(2);
    check("zc_early", sw_if.gn, 1'b1);
    tick(1);
    check("zc_gn_off", sw_if.gn, 1'b0);
    check("zc_busy", sw_if.busy, 1'b1);
    sw_if.zc = 1'b0;
    tick(2);

    // busy drops when DEAD_NP ends, 7 edges after gn_ack falls
    sw_if.gn_ack = 1'b0;
    tick(6);
    check("dead_np_busy", sw_if.busy, 1'b1);
    tick(1);
    check("dead_np_idle", sw_if.busy, 1'b0);

    // uv and oc together: oc wins
    sw_if.uv = 1'b1;
    sw_if.oc = 1'b1;
    tick(20);
    check("uv_oc_gp", sw_if.gp, 1'b0);
    check("uv_oc_busy", sw_if.busy, 1'b0);
    sw_if.oc = 1'b0;
    tick(2);
    check("oc_rel_early", sw_if.gp, 1'b0);
    tick(1);
    check("oc_rel_gp", sw_if.gp, 1'b1);

    // Drive through to N_ON, then reset mid-cycle with gn_ack still high
    sw_if.uv = 1'b0;
    sw_if.gp_ack = 1'b1;
    sw_if.oc = 1'b1;
    tick(11);
    check("cycle2_gp_off", sw_if.gp, 1'b0);
    sw_if.oc = 1'b0;
    sw_if.gp_ack = 1'b0;
    tick(7);
    check("cycle2_gn_on", sw_if.gn, 1'b1);
    sw_if.gn_ack = 1'b1;
    tick(3);
    check("n_on_busy", sw_if.busy, 1'b1);
    rst = 1'b1;
    tick(1);
    check("midrst_gn", sw_if.gn, 1'b0);
    check("midrst_busy", sw_if.busy, 1'b0);
    check("midrst_gp", sw_if.gp, 1'b0);
    check("midrst_fault", sw_if.fault, 1'b0);
    rst = 1'b0;
    sw_if.uv = 1'b1;
    tick(10);
    check("uv_blocked_gn_ack", sw_if.gp, 1'b0);
    sw_if.gn_ack = 1'b0;
    tick(2);
    check("gn_ack_low_early", sw_if.gp, 1'b0);
    tick(1);
    check("gn_ack_low_gp", sw_if.gp, 1'b1);
    sw_if.uv = 1'b0;

`ifdef SWCTRL_ACK_TIMEOUT_EN
    // gp_ack stuck high after gp falls: FAULT on the 65th waiting edge
    sw_if.gp_ack = 1'b1;
    sw_if.oc = 1'b1;
    tick(11);
    check("tmo_gp_off", sw_if.gp, 1'b0);
    sw_if.oc = 1'b0;
    tick(64);
    check("tmo_early", sw_if.fault, 1'b0);
    tick(1);
    check("tmo_fault", sw_if.fault, 1'b1);
    check("tmo_gn", sw_if.gn, 1'b0);
    check("tmo_busy", sw_if.busy, 1'b1);
    sw_if.fault_clr = 1'b1;
    tick(3);
    check("clr_blocked", sw_if.fault, 1'b1);
    sw_if.fault_clr = 1'b0;
    sw_if.gp_ack = 1'b0;
    tick(2);
    sw_if.fault_clr = 1'b1;
    tick(1);
    check("clr_fault", sw_if.fault, 1'b0);
    check("clr_busy", sw_if.busy, 1'b0);
    sw_if.fault_clr = 1'b0;
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
